// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execution-stage ALU with a 2-entry in-order result queue
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH-1:0] alu_res;
  logic             alu_lt;
  logic             alu_ltu;

  logic [WIDTH-1:0] q_res [2];
  logic             q_zero [2];
  logic             q_neg [2];
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;

  // last popped entry, shown while the queue is empty so outputs hold steady
  logic [WIDTH-1:0] last_res;
  logic             last_zero;
  logic             last_neg;

  logic accept;
  logic pop;

  assign alu_lt  = $signed(src_a) < $signed(src_b);
  assign alu_ltu = src_a < src_b;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b100:  alu_res = src_a ^ src_b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, alu_lt};
      3'b110:  alu_res = src_b;
      default: alu_res = {{(WIDTH-1){1'b0}}, alu_ltu};
    endcase
  end

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_res[i]  <= '0;
        q_zero[i] <= 1'b0;
        q_neg[i]  <= 1'b0;
      end
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      last_res  <= '0;
      last_zero <= 1'b0;
      last_neg  <= 1'b0;
    end else begin
      if (accept) begin
        q_res[wr_ptr]  <= alu_res;
        q_zero[wr_ptr] <= (alu_res == '0);
        q_neg[wr_ptr]  <= alu_res[WIDTH-1];
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        last_res  <= q_res[rd_ptr];
        last_zero <= q_zero[rd_ptr];
        last_neg  <= q_neg[rd_ptr];
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign result = out_valid ? q_res[rd_ptr]  : last_res;
  assign zero   = out_valid ? q_zero[rd_ptr] : last_zero;
  assign neg    = out_valid ? q_neg[rd_ptr]  : last_neg;

endmodule
